// File: rtl/sr_data_mem_pkg.sv
// Shared constants for the data memory: MMIO select bit, register offsets, access sizes.
// Also holds the load lane-extraction and extension helper.
package sr_data_mem_pkg;

  localparam int MMIO_SEL_BIT = 31;

  localparam logic [2:0] OFF_GPIO    = 3'd0;
  localparam logic [2:0] OFF_CYCLE   = 3'd1;
  localparam logic [2:0] OFF_STORES  = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_ERRADDR = 3'd4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Word beats half beats byte; no strobe at all also means word.
  function automatic size_e decode_size(input logic b, input logic h, input logic w);
    if (w) return SZ_WORD;
    if (h) return SZ_HALF;
    if (b) return SZ_BYTE;
    return SZ_WORD;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input size_e sz,
                                               input logic [1:0] ofs, input logic sgn);
    logic [15:0] h;
    logic [7:0]  b;
    h = ofs[1] ? word[31:16] : word[15:0];
    b = word[8*ofs +: 8];
    case (sz)
      SZ_BYTE: return {{24{sgn & b[7]}}, b};
      SZ_HALF: return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/sr_dmem_mmio.sv
// MMIO register file: GPIO, free-running CYCLE, STORES counter, sticky error flag and its address.
// Writes arrive pre-qualified (aligned word stores only); reads are combinational by offset.
module sr_dmem_mmio
  import sr_data_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [2:0]  off,
  input  logic [31:0] wdata,
  input  logic        ram_store,
  input  logic        mis_store,
  input  logic [31:0] addr,
  output logic [31:0] rdata,
  output logic [31:0] gpio,
  output logic        err
);

  logic [31:0] cycle;
  logic [31:0] stores;
  logic [31:0] err_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio     <= '0;
      cycle    <= '0;
      stores   <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      if (wr && off == OFF_GPIO) gpio <= wdata;
      cycle <= (wr && off == OFF_CYCLE) ? wdata : cycle + 32'd1;
      if (wr && off == OFF_STORES) stores <= wdata;
      else if (ram_store)          stores <= stores + 32'd1;
      // First misaligned store wins; later ones leave the captured address alone.
      if (mis_store && !err) begin
        err      <= 1'b1;
        err_addr <= addr;
      end else if (wr && off == OFF_STATUS && wdata[0]) begin
        err <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_GPIO:    rdata = gpio;
      OFF_CYCLE:   rdata = cycle;
      OFF_STORES:  rdata = stores;
      OFF_STATUS:  rdata = {31'd0, err};
      OFF_ERRADDR: rdata = err_addr;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/sr_data_mem.sv
// Data memory for the single-cycle core: byte-lane RAM stores, combinational extended loads.
// MMIO window (GPIO, counters, error capture) only when SR_DMEM_MMIO_EN is defined.
module sr_data_mem
  import sr_data_mem_pkg::*;
#(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmAddr,
  input  logic [31:0] dmDataW,
  input  logic        dmWe,
  input  logic        w_byte,
  input  logic        w_half,
  input  logic        w_word,
  input  logic        sign,
  output logic [31:0] dmDataR,
  output logic [31:0] gpioOut,
  output logic        misalignErr
);

  localparam int AW = $clog2(WORDS);

  logic [31:0]   mem [WORDS];
  size_e         sz;
  logic [AW-1:0] idx;
  logic          misaligned;
  logic          sel_mmio;
  logic          ram_we;
  logic          mis_store;
  logic [3:0]    lane_en;
  logic [31:0]   wdat;
  logic [31:0]   mmio_rdata;
  logic [31:0]   word_r;
  logic          unused_addr;

  assign sz          = decode_size(w_byte, w_half, w_word);
  assign idx         = dmAddr[AW+1:2];
  assign unused_addr = ^dmAddr;
  assign misaligned  = (sz == SZ_HALF && dmAddr[0]) || (sz == SZ_WORD && dmAddr[1:0] != 2'b00);

  always_comb begin
    lane_en = 4'b1111;
    wdat    = dmDataW;
    case (sz)
      SZ_BYTE: begin
        lane_en = 4'b0001 << dmAddr[1:0];
        wdat    = {4{dmDataW[7:0]}};
      end
      SZ_HALF: begin
        lane_en = dmAddr[1] ? 4'b1100 : 4'b0011;
        wdat    = {2{dmDataW[15:0]}};
      end
      default: ;
    endcase
  end

  // Sub-word stores into the MMIO window are silently dropped, so they never flag an error.
  assign mis_store = dmWe && misaligned && (!sel_mmio || sz == SZ_WORD);
  assign ram_we    = dmWe && !misaligned && !sel_mmio;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

`ifdef SR_DMEM_MMIO_EN
  logic mmio_wr;

  assign sel_mmio = dmAddr[MMIO_SEL_BIT];
  assign mmio_wr  = dmWe && sel_mmio && sz == SZ_WORD && !misaligned;

  sr_dmem_mmio u_mmio (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (mmio_wr),
    .off       (dmAddr[4:2]),
    .wdata     (dmDataW),
    .ram_store (ram_we),
    .mis_store (mis_store),
    .addr      (dmAddr),
    .rdata     (mmio_rdata),
    .gpio      (gpioOut),
    .err       (misalignErr)
  );
`else
  assign sel_mmio   = 1'b0;
  assign mmio_rdata = '0;
  assign gpioOut    = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         misalignErr <= 1'b0;
    else if (mis_store) misalignErr <= 1'b1;
  end
`endif

  assign word_r  = sel_mmio ? mmio_rdata : mem[idx];
  assign dmDataR = load_extract(word_r, sz, dmAddr[1:0], sign);

endmodule

// File: tb/tb_sr_data_mem.sv
// Directed bench for sr_data_mem; MMIO checks are compiled in with SR_DMEM_MMIO_EN.
module tb_sr_data_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dmAddr = '0;
  logic [31:0] dmDataW = '0;
  logic        dmWe = 1'b0;
  logic        w_byte = 1'b0;
  logic        w_half = 1'b0;
  logic        w_word = 1'b1;
  logic        sign = 1'b0;
  logic [31:0] dmDataR;
  logic [31:0] gpioOut;
  logic        misalignErr;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int B = 0, H = 1, W = 2, NONE = 3;
  localparam logic [31:0] MMIO = 32'h8000_0000;

  sr_data_mem #(.WORDS(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dmAddr      (dmAddr),
    .dmDataW     (dmDataW),
    .dmWe        (dmWe),
    .w_byte      (w_byte),
    .w_half      (w_half),
    .w_word      (w_word),
    .sign        (sign),
    .dmDataR     (dmDataR),
    .gpioOut     (gpioOut),
    .misalignErr (misalignErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_size(input int sz);
    w_byte = (sz == B);
    w_half = (sz == H);
    w_word = (sz == W);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input int sz);
    @(negedge clk);
    dmAddr = a; dmDataW = d; set_size(sz); dmWe = 1'b1;
    @(negedge clk);
    dmWe = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input int sz,
                          input logic sg, input logic [31:0] exp);
    @(negedge clk);
    dmAddr = a; set_size(sz); sign = sg;
    #1;
    check(tag, dmDataR, exp);
  endtask

  initial begin
    #2;
    check("rst_gpio", gpioOut, 32'h0);
    check("rst_err", {31'd0, misalignErr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // byte lane write into a word
    store(32'h10, 32'h1122_3344, W);
    store(32'h11, 32'h1234_56AA, B);
    load_chk("lane_word",   32'h10, W, 1'b0, 32'h1122_AA44);
    load_chk("lane_byte_s", 32'h11, B, 1'b1, 32'hFFFF_FFAA);
    load_chk("lane_byte_z", 32'h11, B, 1'b0, 32'h0000_00AA);
    load_chk("lane_byte3",  32'h13, B, 1'b1, 32'h0000_0011);
    load_chk("lane_half_s", 32'h12, H, 1'b1, 32'h0000_1122);
    load_chk("word_ign_lo", 32'h12, W, 1'b0, 32'h1122_AA44);

    // upper halfword lane
    store(32'h20, 32'hCAFE_BABE, W);
    store(32'h22, 32'h7777_8001, H);
    load_chk("half_s",     32'h22, H, 1'b1, 32'hFFFF_8001);
    load_chk("half_word",  32'h20, W, 1'b0, 32'h8001_BABE);
    load_chk("half_lo_z",  32'h20, H, 1'b0, 32'h0000_BABE);
    load_chk("half_lo_s",  32'h21, H, 1'b1, 32'hFFFF_BABE);

    // misaligned stores leave RAM alone and set the sticky flag
    store(32'h30, 32'h0102_0304, W);
    store(32'h13, 32'hDEAD_BEEF, W);
    check("mis_err_set", {31'd0, misalignErr}, 32'h1);
    load_chk("mis_word_ram", 32'h10, W, 1'b0, 32'h1122_AA44);
    store(32'h31, 32'h0000_5555, H);
    load_chk("mis_half_ram", 32'h30, W, 1'b0, 32'h0102_0304);
    check("mis_err_held", {31'd0, misalignErr}, 32'h1);

    // no size strobe means word; depth wraps at 64 words
    store(32'h40, 32'h0BAD_F00D, NONE);
    load_chk("none_is_word", 32'h40, W, 1'b0, 32'h0BAD_F00D);
    store(32'h100, 32'h600D_CAFE, W);
    load_chk("alias_0x100", 32'h000, W, 1'b0, 32'h600D_CAFE);

`ifdef SR_DMEM_MMIO_EN
    load_chk("erraddr",     MMIO + 32'h10, W, 1'b0, 32'h0000_0013);
    load_chk("status_rd",   MMIO + 32'h0C, W, 1'b0, 32'h0000_0001);
    store(MMIO + 32'h0C, 32'h1, W);
    check("status_clear", {31'd0, misalignErr}, 32'h0);

    store(MMIO, 32'h0000_005A, W);
    check("gpio_write", gpioOut, 32'h0000_005A);
    store(MMIO, 32'h0000_00FF, B);
    check("gpio_subword", gpioOut, 32'h0000_005A);
    check("gpio_sub_noerr", {31'd0, misalignErr}, 32'h0);
    load_chk("gpio_byte_rd", MMIO + 32'h1, B, 1'b0, 32'h0000_0000);

    store(MMIO + 32'h08, 32'h0, W);
    store(32'h44, 32'h1, W);
    store(32'h45, 32'h2, B);
    store(32'h46, 32'h3, H);
    load_chk("stores_3", MMIO + 32'h08, W, 1'b0, 32'h3);

    store(MMIO + 32'h04, 32'hFFFF_FFFF, W);
    dmAddr = MMIO + 32'h04; set_size(W);
    #1;
    check("cycle_load", dmDataR, 32'hFFFF_FFFF);
    load_chk("cycle_wrap", MMIO + 32'h04, W, 1'b0, 32'h0);
    load_chk("mmio_off5", MMIO + 32'h14, W, 1'b0, 32'h0);
`else
    store(32'h8000_0050, 32'h5151_A0A0, W);
    load_chk("no_mmio_alias", 32'h50, W, 1'b0, 32'h5151_A0A0);
    check("gpio_tied", gpioOut, 32'h0);
`endif

    // short asynchronous reset pulse
    store(32'h17, 32'h0, W);
    check("pre_rst_err", {31'd0, misalignErr}, 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_gpio", gpioOut, 32'h0);
    check("arst_err", {31'd0, misalignErr}, 32'h0);
    #1 rst_n = 1'b1;
`ifdef SR_DMEM_MMIO_EN
    repeat (4) @(negedge clk);
    load_chk("cycle_after_rst", MMIO + 32'h04, W, 1'b0, 32'd5);
    load_chk("stores_rst",  MMIO + 32'h08, W, 1'b0, 32'h0);
    load_chk("erraddr_rst", MMIO + 32'h10, W, 1'b0, 32'h0);
`endif
    load_chk("ram_kept", 32'h10, W, 1'b0, 32'h1122_AA44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
